// File: rtl/rgb_led_fader.sv
// RGB LED fader: button-driven color/brightness modes, per-channel ramped fades,
// and a shared PWM counter whose duty is latched once per period.
module rgb_led_fader #(
  parameter int DUTY_W     = 7,
  parameter int NUM_COLOR  = 7,
  parameter int NUM_BRIGHT = 4,
  parameter int PWM_DIV    = 78,
  parameter int FADE_DIV   = 100_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       short_press,
  input  logic       long_press,
  input  logic       timer_end,
  input  logic       fade_en,
  output logic [2:0] led,
  output logic [2:0] color_mode,
  output logic [1:0] brightness_mode,
  output logic       fading
);

  localparam int PWM_CW  = $clog2(PWM_DIV + 1);
  localparam int FADE_CW = $clog2(FADE_DIV + 1);

  localparam logic [DUTY_W-1:0]  FS          = DUTY_W'((2 ** DUTY_W) - 1);
  localparam logic [DUTY_W-1:0]  PWM_TOP     = DUTY_W'((2 ** DUTY_W) - 2);
  localparam logic [PWM_CW-1:0]  PWM_LAST    = PWM_CW'(PWM_DIV - 1);
  localparam logic [FADE_CW-1:0] FADE_LAST   = FADE_CW'(FADE_DIV - 1);
  localparam logic [2:0]         COLOR_LAST  = 3'(NUM_COLOR - 1);
  localparam logic [1:0]         BRIGHT_LAST = 2'(NUM_BRIGHT - 1);

  // Channel enables per color index, bit order {blue, green, red}.
  function automatic logic [2:0] color_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b001;
      3'd1:    m = 3'b010;
      3'd2:    m = 3'b100;
      3'd3:    m = 3'b011;
      3'd4:    m = 3'b110;
      3'd5:    m = 3'b101;
      3'd6:    m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Each brightness step below the top divides the duty by four.
  function automatic logic [DUTY_W-1:0] level_scale(input logic on, input logic [1:0] level);
    int sh;
    sh = 2 * (NUM_BRIGHT - 1 - int'(level));
    if (!on || level == 2'd0) return '0;
    return FS >> sh;
  endfunction

  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                             input logic [DUTY_W-1:0] tgt);
    if (cur < tgt) return cur + DUTY_W'(1);
    if (cur > tgt) return cur - DUTY_W'(1);
    return cur;
  endfunction

  logic [2:0]        mask_p0;
  logic [DUTY_W-1:0] target_p1 [3];
  logic [DUTY_W-1:0] cur_p2    [3];
  logic [DUTY_W-1:0] shadow_p3 [3];
  logic [FADE_CW-1:0] fade_cnt;
  logic               fade_step;
  logic [PWM_CW-1:0]  pwm_pre;
  logic               pwm_tick;
  logic [DUTY_W-1:0]  pwm_cnt;
  logic               pwm_wrap;

  // Stage p0: mode registers
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      color_mode      <= '0;
      brightness_mode <= '0;
    end else if (timer_end) begin
      brightness_mode <= '0;
    end else if (long_press) begin
      brightness_mode <= (brightness_mode == BRIGHT_LAST) ? 2'd0 : brightness_mode + 2'd1;
    end else if (short_press) begin
      color_mode <= (color_mode == COLOR_LAST) ? 3'd0 : color_mode + 3'd1;
    end
  end

  assign mask_p0 = color_mask(color_mode);

  // Stage p1: per-channel target
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 3; i++) target_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) target_p1[i] <= level_scale(mask_p0[i], brightness_mode);
    end
  end

  assign fade_step = (fade_cnt == FADE_LAST);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) fade_cnt <= '0;
    else         fade_cnt <= fade_step ? '0 : fade_cnt + FADE_CW'(1);
  end

  // Stage p2: current (possibly ramping) duty
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 3; i++) cur_p2[i] <= '0;
    end else if (!fade_en) begin
      for (int i = 0; i < 3; i++) cur_p2[i] <= target_p1[i];
    end else if (fade_step) begin
      for (int i = 0; i < 3; i++) cur_p2[i] <= ramp(cur_p2[i], target_p1[i]);
    end
  end

  always_comb begin
    fading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cur_p2[i] != target_p1[i]) fading = 1'b1;
    end
  end

  assign pwm_tick = (pwm_pre == PWM_LAST);
  assign pwm_wrap = pwm_tick && (pwm_cnt == PWM_TOP);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pwm_pre <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_pre <= pwm_tick ? '0 : pwm_pre + PWM_CW'(1);
      if (pwm_tick) pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + DUTY_W'(1);
    end
  end

  // Stage p3: duty frozen for a whole PWM period, then compared
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 3; i++) shadow_p3[i] <= '0;
    end else if (pwm_wrap) begin
      for (int i = 0; i < 3; i++) shadow_p3[i] <= cur_p2[i];
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      led <= '0;
    end else begin
      for (int i = 0; i < 3; i++) led[i] <= (pwm_cnt < shadow_p3[i]);
    end
  end

endmodule
